pin_entry_terminal: RTL
=======================

Name: pin_entry_terminal

Overview:
- Keypad-side front end for the parking controller. It produces the `pin[7:0]` / `pin_validation` pair that the controller consumes.
- Raw keypad strobes are debounced. Hex digits are assembled MSB-first into a PIN word.
- On ENTER, the complete PIN is presented with exactly one single-cycle `pin_validation` pulse, so the controller counts one attempt per ENTER.
- Handles CLEAR, short entries and inactivity timeout locally; none of these reach the controller.

Parameters:
- DIGITS, 2, number of 4-bit hex digits per PIN; PIN width = 4*DIGITS (8 at default).
- DEBOUNCE_CYCLES, 4, consecutive identical samples required to accept a press or a release (≥2).
- TIMEOUT_CYCLES, 32, idle cycles after the last accepted press before a partial entry is discarded (≥4).

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- key_valid  in  1  raw level: a digit key is held.
- key_code  in  4  raw digit value; meaningful while `key_valid`=1.
- key_enter  in  1  raw level: ENTER key held.
- key_clear  in  1  raw level: CLEAR key held.
- pin  out  4*DIGITS  last submitted PIN; stable between submissions.
- pin_validation  out  1  one-cycle strobe; `pin` is valid in the same cycle.
- digit_count  out  $clog2(DIGITS+1)  digits currently buffered (for display).
- entry_error  out  1  one-cycle pulse: ENTER pressed with fewer than DIGITS digits.
- entry_timeout  out  1  one-cycle pulse: partial entry discarded by timeout.

Behaviour:
- Reset (reset, synchronous, active-high; clock clock): all outputs = 0, buffer = 0, timer = 0, FSM = IDLE.
  - Debouncer enters WAIT_RELEASE after reset.
  - A key still held through reset must be released and pressed again before it counts.
- Debounce:
  - key_any = `key_valid` | `key_enter` | `key_clear`.
  - Press is accepted at the posedge where key_any has been sampled high on DEBOUNCE_CYCLES consecutive edges.
  - At that edge, the key class is latched with priority CLEAR > ENTER > DIGIT, together with `key_code`.
  - No further press is accepted until key_any has been sampled low DEBOUNCE_CYCLES consecutive times. Bounce during either window restarts that window's count.
  - The internal press event is a registered one-cycle flag.
- FSM (acts on the press event at the following edge):
  - IDLE, `digit_count`=0:
    - DIGIT: shift in, go to COLLECT.
    - ENTER: `entry_error` pulse, stay in IDLE.
    - CLEAR: no-op.
  - COLLECT, 0<count<DIGITS:
    - DIGIT: buffer <= {buffer[4*DIGITS-5:0], key_code}, count+1; go to FULL when count reaches DIGITS.
    - ENTER: `entry_error` pulse, clear buffer, go to IDLE.
    - CLEAR: clear buffer, go to IDLE.
  - FULL, count=DIGITS:
    - DIGIT: ignored, no shift, but the timer still restarts.
    - ENTER: go to SEND.
    - CLEAR: go to IDLE.
  - SEND (exactly one cycle):
    - `pin` <= buffer and `pin_validation`=1 in this cycle.
    - Buffer and count clear; go to IDLE.
    - `pin` keeps its value afterwards.
  - Latency: `pin_validation` is high in the cycle after the edge that registered the FSM step for ENTER, i.e. DEBOUNCE_CYCLES+2 edges after ENTER is first sampled high.
- Timer:
  - Clears on every accepted press and in IDLE.
  - Increments each cycle in COLLECT or FULL.
  - When it reaches TIMEOUT_CYCLES-1: `entry_timeout` pulse, clear buffer, go to IDLE.
  - If a press event and timer expiry coincide, the press wins and the timer restarts.
- Width rules:
  - Timer width is $clog2(TIMEOUT_CYCLES); it saturates and never wraps.
  - Debounce counter width is $clog2(DEBOUNCE_CYCLES+1).
- Pulse exclusivity: `pin_validation`, `entry_error` and `entry_timeout` are mutually exclusive; never more than one high in any cycle.
- Reset mid-entry: the buffer is lost, no pulse is emitted, and `pin` returns to 0.

Decomposition:
- Shared package parking_pkg holds:
  - FSM state encoding typedef;
  - key class enum (NONE/DIGIT/ENTER/CLEAR);
  - PIN_CORRECT = 8'h3D, which the controller also uses.
- One sub-module, key_debouncer: inputs are the raw key lines; outputs are the registered press-event flag, the key class and the latched code.

Test Plan:
- Enter 3, then D, then ENTER, each held 6 cycles and released 6 cycles → exactly one `pin_validation` pulse with `pin`=8'h3D; `digit_count` sequence 1, 2, 0.
- `key_valid` with `key_code`=4'h7 toggling 1-0-1-1-0-1-1-1-1 (never DEBOUNCE_CYCLES=4 consecutive highs until the final run) → exactly one digit accepted, `digit_count`=1.
- Enter 5, then ENTER → `entry_error` pulse, no `pin_validation`, `digit_count`=0, `pin` unchanged.
- Enter A, then wait 40 idle cycles → `entry_timeout` pulse once (TIMEOUT_CYCLES=32 after the press), `digit_count`=0. A subsequent 3, D, ENTER yields `pin`=8'h3D.
- Enter 1, 2, 9 (third digit ignored), CLEAR, then 3, D, ENTER → `pin`=8'h3D. Variant without CLEAR: 1, 2, 9, ENTER → `pin`=8'h12.
- Hold `key_enter` across a reset assertion mid-entry → `pin`=0, no pulses, and no ENTER is accepted until `key_enter` has been released for 4 cycles and pressed again.

Source files
------------

// File: rtl/parking_pkg.sv
// Types and constants shared between the keypad front end and the parking controller.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_FULL,
        ST_SEND
    } entry_state_t;

    typedef enum logic [1:0] {
        KEY_NONE,
        KEY_DIGIT,
        KEY_ENTER,
        KEY_CLEAR
    } key_class_t;

    typedef enum logic {
        DB_WAIT_PRESS,
        DB_WAIT_RELEASE
    } debounce_state_t;

    localparam logic [7:0] PIN_CORRECT = 8'h3D;

    // CLEAR outranks ENTER, which outranks a digit, when several lines are held together.
    function automatic key_class_t classify_key(input logic enter, input logic clear);
        if (clear) begin
            return KEY_CLEAR;
        end
        if (enter) begin
            return KEY_ENTER;
        end
        return KEY_DIGIT;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Debounces the combined keypad activity and emits a one-cycle press event with
// the key class and digit code captured at the accepting edge.
module key_debouncer
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       key_enter,
    input  logic       key_clear,
    output logic       press_event,
    output key_class_t press_class,
    output logic [3:0] press_code
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    debounce_state_t  state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             press_reg;
    key_class_t       class_reg;
    logic [3:0]       code_reg;
    logic             key_any;

    assign key_any     = key_valid | key_enter | key_clear;
    assign press_event = press_reg;
    assign press_class = class_reg;
    assign press_code  = code_reg;

    // Starting in WAIT_RELEASE forces a key held through reset to be released first.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= DB_WAIT_RELEASE;
            count_reg <= '0;
            press_reg <= 1'b0;
            class_reg <= KEY_NONE;
            code_reg  <= '0;
        end else begin
            press_reg <= 1'b0;
            unique case (state_reg)
                DB_WAIT_PRESS: begin
                    if (!key_any) begin
                        count_reg <= '0;
                    end else if (count_reg == CNT_LAST) begin
                        press_reg <= 1'b1;
                        class_reg <= classify_key(key_enter, key_clear);
                        code_reg  <= key_code;
                        count_reg <= '0;
                        state_reg <= DB_WAIT_RELEASE;
                    end else begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end
                DB_WAIT_RELEASE: begin
                    if (key_any) begin
                        count_reg <= '0;
                    end else if (count_reg == CNT_LAST) begin
                        count_reg <= '0;
                        state_reg <= DB_WAIT_PRESS;
                    end else begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= DB_WAIT_RELEASE;
            endcase
        end
    end

endmodule

// File: rtl/pin_entry_terminal.sv
// Keypad front end: assembles debounced hex digits into a PIN and submits it to the
// parking controller with a single pin_validation strobe per ENTER.
module pin_entry_terminal
    import parking_pkg::*;
#(
    parameter int DIGITS          = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         key_valid,
    input  logic [3:0]                   key_code,
    input  logic                         key_enter,
    input  logic                         key_clear,
    output logic [4*DIGITS-1:0]          pin,
    output logic                         pin_validation,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         entry_error,
    output logic                         entry_timeout
);

    localparam int PIN_W = 4 * DIGITS;
    localparam int CW    = $clog2(DIGITS + 1);
    localparam int TW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] COUNT_LAST_FREE = CW'(DIGITS - 1);
    localparam logic [TW-1:0] TIMER_LAST      = TW'(TIMEOUT_CYCLES - 1);

    logic       press_evt;
    key_class_t press_class;
    logic [3:0] press_code;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock      (clock),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_enter  (key_enter),
        .key_clear  (key_clear),
        .press_event(press_evt),
        .press_class(press_class),
        .press_code (press_code)
    );

    entry_state_t     state_reg;
    logic [PIN_W-1:0] buffer_reg;
    logic [PIN_W-1:0] shifted_next;
    logic [CW-1:0]    count_reg;
    logic [TW-1:0]    timer_reg;
    logic [PIN_W-1:0] pin_reg;
    logic             pin_validation_reg;
    logic             entry_error_reg;
    logic             entry_timeout_reg;

    assign shifted_next   = (buffer_reg << 4) | PIN_W'(press_code);
    assign pin            = pin_reg;
    assign pin_validation = pin_validation_reg;
    assign digit_count    = count_reg;
    assign entry_error    = entry_error_reg;
    assign entry_timeout  = entry_timeout_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg          <= ST_IDLE;
            buffer_reg         <= '0;
            count_reg          <= '0;
            timer_reg          <= '0;
            pin_reg            <= '0;
            pin_validation_reg <= 1'b0;
            entry_error_reg    <= 1'b0;
            entry_timeout_reg  <= 1'b0;
        end else begin
            pin_validation_reg <= 1'b0;
            entry_error_reg    <= 1'b0;
            entry_timeout_reg  <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    timer_reg <= '0;
                    if (press_evt && press_class == KEY_DIGIT) begin
                        buffer_reg <= shifted_next;
                        count_reg  <= CW'(1);
                        state_reg  <= (DIGITS == 1) ? ST_FULL : ST_COLLECT;
                    end else if (press_evt && press_class == KEY_ENTER) begin
                        entry_error_reg <= 1'b1;
                    end
                end
                ST_COLLECT, ST_FULL: begin
                    // A press arriving on the expiry cycle wins and restarts the timer.
                    if (press_evt) begin
                        timer_reg <= '0;
                        unique case (press_class)
                            KEY_DIGIT: begin
                                if (state_reg == ST_COLLECT) begin
                                    buffer_reg <= shifted_next;
                                    count_reg  <= count_reg + CW'(1);
                                    if (count_reg == COUNT_LAST_FREE) begin
                                        state_reg <= ST_FULL;
                                    end
                                end
                            end
                            KEY_ENTER: begin
                                if (state_reg == ST_FULL) begin
                                    state_reg <= ST_SEND;
                                end else begin
                                    entry_error_reg <= 1'b1;
                                    buffer_reg      <= '0;
                                    count_reg       <= '0;
                                    state_reg       <= ST_IDLE;
                                end
                            end
                            KEY_CLEAR: begin
                                buffer_reg <= '0;
                                count_reg  <= '0;
                                state_reg  <= ST_IDLE;
                            end
                            default: ;
                        endcase
                    end else if (timer_reg == TIMER_LAST) begin
                        entry_timeout_reg <= 1'b1;
                        buffer_reg        <= '0;
                        count_reg         <= '0;
                        timer_reg         <= '0;
                        state_reg         <= ST_IDLE;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                ST_SEND: begin
                    pin_reg            <= buffer_reg;
                    pin_validation_reg <= 1'b1;
                    buffer_reg         <= '0;
                    count_reg          <= '0;
                    state_reg          <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
